// File: rtl/fetch_stage0.sv
// Stage-0 fetch controller: owns the PC, issues one-cycle-latency instruction reads and
// registers decoded fields into stage 1, with a one-entry skid buffer across stalls.
module fetch_stage0 #(
   parameter int unsigned CODE_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       halt,
   input  logic                       branch_taken,
   input  logic [CODE_ADDR_WIDTH-1:0] branch_target,
   input  logic                       stage1_stalled,
   output logic [CODE_ADDR_WIDTH-1:0] inst_mem_addr,
   output logic                       inst_mem_rd_en,
   input  logic [63:0]                inst_mem_data,
   output logic [15:0]                opcode,
   output logic [7:0]                 jt,
   output logic [7:0]                 jf,
   output logic [31:0]                imm,
   output logic [CODE_ADDR_WIDTH-1:0] inst_pc,
   output logic                       stage0_valid,
   output logic                       running
);

   localparam int unsigned AW     = CODE_ADDR_WIDTH;
   localparam int unsigned WORD_W = 64;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic [AW-1:0]       r_pc;
   logic [AW-1:0]       r_inflight_pc;
   logic                r_inflight;
   logic [WORD_W-1:0]   r_skid_word;
   logic [AW-1:0]       r_skid_pc;
   logic                r_skid_valid;
   logic [15:0]         r_opcode;
   logic [7:0]          r_jt;
   logic [7:0]          r_jf;
   logic [31:0]         r_imm;
   logic [AW-1:0]       r_inst_pc;
   logic                r_valid;

   logic                w_fetch;
   logic                w_start;
   logic                w_halt;
   logic                w_redirect;
   logic                w_issue;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and per-cycle control decode; halt outranks branch, branch outranks stall
   always_comb begin
      w_next_state = r_state;
      w_fetch      = (r_state == S_FETCH);
      w_start      = 1'b0;
      w_halt       = 1'b0;
      w_redirect   = 1'b0;
      w_issue      = 1'b0;
      case (r_state)
         S_IDLE, S_HALTED: begin
            if (start) begin
               w_start      = 1'b1;
               w_next_state = S_FETCH;
            end
         end
         S_FETCH: begin
            if (halt) begin
               w_halt       = 1'b1;
               w_next_state = S_HALTED;
            end else if (branch_taken) begin
               w_redirect = 1'b1;
            end else if (!stage1_stalled) begin
               w_issue = 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // PC, in-flight tracking, skid buffer and stage-1 output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc          <= '0;
         r_inflight_pc <= '0;
         r_inflight    <= 1'b0;
         r_skid_word   <= '0;
         r_skid_pc     <= '0;
         r_skid_valid  <= 1'b0;
         r_opcode      <= '0;
         r_jt          <= '0;
         r_jf          <= '0;
         r_imm         <= '0;
         r_inst_pc     <= '0;
         r_valid       <= 1'b0;
      end else if (w_start) begin
         r_pc         <= '0;
         r_inflight   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_valid      <= 1'b0;
      end else if (w_halt) begin
         r_inflight   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_valid      <= 1'b0;
      end else if (w_redirect) begin
         r_pc         <= branch_target;
         r_inflight   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_valid      <= 1'b0;
      end else if (w_fetch) begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc          <= r_pc + AW'(1);
            r_inflight_pc <= r_pc;
         end
         if (stage1_stalled) begin
            // No read issues while stalled, so at most one word can land here
            if (r_inflight) begin
               r_skid_word  <= inst_mem_data;
               r_skid_pc    <= r_inflight_pc;
               r_skid_valid <= 1'b1;
            end
         end else if (r_skid_valid) begin
            r_opcode     <= r_skid_word[63:48];
            r_jt         <= r_skid_word[47:40];
            r_jf         <= r_skid_word[39:32];
            r_imm        <= r_skid_word[31:0];
            r_inst_pc    <= r_skid_pc;
            r_valid      <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (r_inflight) begin
            r_opcode  <= inst_mem_data[63:48];
            r_jt      <= inst_mem_data[47:40];
            r_jf      <= inst_mem_data[39:32];
            r_imm     <= inst_mem_data[31:0];
            r_inst_pc <= r_inflight_pc;
            r_valid   <= 1'b1;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign inst_mem_addr  = r_pc;
   assign inst_mem_rd_en = w_issue;
   assign opcode         = r_opcode;
   assign jt             = r_jt;
   assign jf             = r_jf;
   assign imm            = r_imm;
   assign inst_pc        = r_inst_pc;
   assign stage0_valid   = r_valid;
   assign running        = w_fetch;

endmodule

// File: tb/tb_fetch_stage0.sv
// Directed bench for fetch_stage0: stimulus pushes expected instruction PCs, a negedge
// monitor pops one entry per newly presented instruction and compares all fields.
module tb_fetch_stage0;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          halt;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic          stage1_stalled;
   logic [AW-1:0] inst_mem_addr;
   logic          inst_mem_rd_en;
   logic [63:0]   inst_mem_data;
   logic [15:0]   opcode;
   logic [7:0]    jt;
   logic [7:0]    jf;
   logic [31:0]   imm;
   logic [AW-1:0] inst_pc;
   logic          stage0_valid;
   logic          running;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [AW-1:0] exp_q[$];
   logic          last_stall = 1'b0;

   always #5 clk = ~clk;

   fetch_stage0 #(.CODE_ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .halt           (halt),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .stage1_stalled (stage1_stalled),
      .inst_mem_addr  (inst_mem_addr),
      .inst_mem_rd_en (inst_mem_rd_en),
      .inst_mem_data  (inst_mem_data),
      .opcode         (opcode),
      .jt             (jt),
      .jf             (jf),
      .imm            (imm),
      .inst_pc        (inst_pc),
      .stage0_valid   (stage0_valid),
      .running        (running)
   );

   function automatic logic [63:0] word_at(input logic [AW-1:0] a);
      logic [15:0] op;
      op = 16'h0020 + 16'(a);
      return {op, a[7:0], a[7:0], 32'(a)};
   endfunction

   // One-cycle-latency instruction memory
   always @(posedge clk) begin
      if (inst_mem_rd_en) inst_mem_data <= word_at(inst_mem_addr);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Remember whether the last edge was a stalled (hold) edge
   always @(posedge clk) last_stall <= stage1_stalled;

   // Monitor: a valid output after a non-stalled edge is a newly presented instruction
   always @(negedge clk) begin
      if (rst === 1'b1 && stage0_valid === 1'b1 && !last_stall) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got inst_pc %0h, expected no instruction", inst_pc);
         end else begin
            logic [AW-1:0] e;
            e = exp_q.pop_front();
            if ({opcode, jt, jf, imm} !== word_at(e) || inst_pc !== e) begin
               n_fail++;
               $display("FAIL sb_word: got pc %0h word %0h expected pc %0h word %0h",
                        inst_pc, {opcode, jt, jf, imm}, e, word_at(e));
            end
         end
      end
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      rst = 1'b0; start = 1'b0; halt = 1'b0; branch_taken = 1'b0;
      branch_target = '0; stage1_stalled = 1'b0; inst_mem_data = '0;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_rd_en",   64'(inst_mem_rd_en), 64'd0);
      chk("rst_valid",   64'(stage0_valid),   64'd0);
      chk("rst_running", 64'(running),        64'd0);
      chk("rst_opcode",  64'(opcode),         64'd0);
      chk("rst_inst_pc", 64'(inst_pc),        64'd0);
      chk("rst_addr",    64'(inst_mem_addr),  64'd0);
      nxt(); rst = 1'b1;
      nxt(); #2 chk("idle_running", 64'(running), 64'd0);

      // Start and stream, stall while word 5 is in flight
      nxt(); start = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back(AW'(i));
      nxt(); start = 1'b0; #2;
      chk("t1_rd_en", 64'(inst_mem_rd_en), 64'd1);
      chk("t1_addr",  64'(inst_mem_addr),  64'd0);
      chk("t1_run",   64'(running),        64'd1);
      nxt(); #2 chk("t2_valid", 64'(stage0_valid), 64'd0);
      nxt(); #2;
      chk("t3_valid",  64'(stage0_valid), 64'd1);
      chk("t3_opcode", 64'(opcode),       64'h20);
      chk("t3_pc",     64'(inst_pc),      64'd0);
      nxt(); nxt(); nxt();
      nxt(); stage1_stalled = 1'b1; #2;
      chk("stall_rd_en", 64'(inst_mem_rd_en), 64'd0);
      chk("stall_pc0",   64'(inst_pc),        64'd4);
      nxt();
      nxt(); #2;
      chk("stall_valid", 64'(stage0_valid), 64'd1);
      chk("stall_pc2",   64'(inst_pc),      64'd4);
      nxt(); stage1_stalled = 1'b0; #2;
      chk("release_rd_en", 64'(inst_mem_rd_en), 64'd1);
      chk("release_addr",  64'(inst_mem_addr),  64'd6);
      chk("release_pc",    64'(inst_pc),        64'd4);
      nxt(); #2 chk("skid_pc",  64'(inst_pc), 64'd5);
      nxt(); #2 chk("after_pc", 64'(inst_pc), 64'd6);

      // Branch while stalled: stall ignored, two bubbles, then target
      nxt(); branch_taken = 1'b1; branch_target = AW'(10'h100); stage1_stalled = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back(AW'(10'h100 + i));
      #2 chk("br_rd_en", 64'(inst_mem_rd_en), 64'd0);
      nxt(); branch_taken = 1'b0; stage1_stalled = 1'b0; #2;
      chk("br1_valid", 64'(stage0_valid),   64'd0);
      chk("br1_rd_en", 64'(inst_mem_rd_en), 64'd1);
      chk("br1_addr",  64'(inst_mem_addr),  64'h100);
      nxt(); #2 chk("br2_valid", 64'(stage0_valid), 64'd0);
      nxt(); #2;
      chk("br3_valid", 64'(stage0_valid), 64'd1);
      chk("br3_pc",    64'(inst_pc),      64'h100);
      nxt();

      // Halt and branch together
      nxt(); halt = 1'b1; branch_taken = 1'b1; branch_target = AW'(10'h055);
      #2 chk("halt_rd_en", 64'(inst_mem_rd_en), 64'd0);
      nxt(); halt = 1'b0; branch_taken = 1'b0; #2;
      chk("halt1_valid", 64'(stage0_valid),   64'd0);
      chk("halt1_run",   64'(running),        64'd0);
      chk("halt1_rd_en", 64'(inst_mem_rd_en), 64'd0);
      nxt(); #2;
      chk("halt2_valid", 64'(stage0_valid),   64'd0);
      chk("halt2_rd_en", 64'(inst_mem_rd_en), 64'd0);

      // Restart at 0, then jump near the top to check PC wrap
      nxt(); start = 1'b1;
      exp_q.push_back(AW'(10'h3FE));
      exp_q.push_back(AW'(10'h3FF));
      exp_q.push_back(AW'(10'h000));
      nxt(); start = 1'b0; #2;
      chk("restart_rd_en", 64'(inst_mem_rd_en), 64'd1);
      chk("restart_addr",  64'(inst_mem_addr),  64'd0);
      nxt(); branch_taken = 1'b1; branch_target = AW'(10'h3FE);
      nxt(); branch_taken = 1'b0; #2 chk("wrap_addr0", 64'(inst_mem_addr), 64'h3FE);
      nxt(); #2 chk("wrap_addr1", 64'(inst_mem_addr), 64'h3FF);
      nxt(); #2;
      chk("wrap_rd_en", 64'(inst_mem_rd_en), 64'd1);
      chk("wrap_addr2", 64'(inst_mem_addr),  64'h000);
      nxt();
      nxt(); stage1_stalled = 1'b1; #2 chk("pre_rst_pc", 64'(inst_pc), 64'd0);

      // Async reset with a word parked in the skid buffer
      nxt(); #2 rst = 1'b0; #1;
      chk("arst_valid",   64'(stage0_valid),   64'd0);
      chk("arst_rd_en",   64'(inst_mem_rd_en), 64'd0);
      chk("arst_running", 64'(running),        64'd0);
      chk("arst_opcode",  64'(opcode),         64'd0);
      chk("arst_inst_pc", 64'(inst_pc),        64'd0);
      chk("arst_addr",    64'(inst_mem_addr),  64'd0);
      nxt(); stage1_stalled = 1'b0;
      nxt(); rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         nxt(); #2;
         chk("post_rst_valid", 64'(stage0_valid), 64'd0);
         chk("post_rst_run",   64'(running),      64'd0);
      end

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
